// File: rtl/md_issue_ctrl_if.sv
// rtl/md_issue_ctrl_if.sv - pipeline/unit handshake bundle for the multiply/divide issue controller
interface md_issue_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [2:0]        d_md_op;
  logic              d_md_read;
  logic              e_valid;
  logic [2:0]        e_md_op;
  logic              req;
  logic              md_busy;
  logic              md_start;
  logic              md_write;
  logic              stall_d;
  logic [1:0]        run_kind;
  logic              err_sync;
  logic              err_overlap;
  logic [PERF_W-1:0] perf_ops;
  logic [PERF_W-1:0] perf_stalls;

  modport master (
    output d_md_op, d_md_read, e_valid, e_md_op, req, md_busy,
    input  md_start, md_write, stall_d, run_kind, err_sync, err_overlap, perf_ops, perf_stalls
  );

  modport slave (
    input  d_md_op, d_md_read, e_valid, e_md_op, req, md_busy,
    output md_start, md_write, stall_d, run_kind, err_sync, err_overlap, perf_ops, perf_stalls
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage multiply/divide issue gating, shadow latency FSM and D-stage stall
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input logic           clk,
  input logic           reset,
  md_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_first;
  logic              r_err_sync;
  logic              r_err_overlap;
  logic [PERF_W-1:0] r_perf_ops;
  logic [PERF_W-1:0] r_perf_stalls;

  logic w_e_start_op;
  logic w_e_wr_op;
  logic w_d_md;
  logic w_idle;
  logic w_start;
  logic w_write;
  logic w_stall;
  logic w_e_mult;

  assign w_e_start_op = (bus.e_md_op >= 3'd1) && (bus.e_md_op <= 3'd4);
  assign w_e_wr_op    = (bus.e_md_op == 3'd5) || (bus.e_md_op == 3'd6);
  assign w_e_mult     = (bus.e_md_op == 3'd1) || (bus.e_md_op == 3'd2);
  assign w_d_md       = ((bus.d_md_op >= 3'd1) && (bus.d_md_op <= 3'd6)) || bus.d_md_read;
  assign w_idle       = (r_state == ST_IDLE);

  assign w_start = bus.e_valid && w_e_start_op && !bus.req && w_idle;
  assign w_write = bus.e_valid && w_e_wr_op && !bus.req && w_idle;
  // Busy from the unit lags the start by one edge, so the start cycle stalls on its own term.
  assign w_stall = w_d_md && (!w_idle || w_start || bus.md_busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_e_mult) begin
            w_state_nxt = ST_MULT;
            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
          end else begin
            w_state_nxt = ST_DIV;
            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
          end
        end
      end
      ST_MULT, ST_DIV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The first cycle after reset is excluded from sync checking while the unit comes out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first       <= 1'b1;
      r_err_sync    <= 1'b0;
      r_err_overlap <= 1'b0;
      r_perf_ops    <= '0;
      r_perf_stalls <= '0;
    end else begin
      r_first <= 1'b0;
      if (!r_first && (bus.md_busy != !w_idle)) begin
        r_err_sync <= 1'b1;
      end
      if (bus.e_valid && (w_e_start_op || w_e_wr_op) && !bus.req && !w_idle) begin
        r_err_overlap <= 1'b1;
      end
      if (w_start && (r_perf_ops != {PERF_W{1'b1}})) begin
        r_perf_ops <= r_perf_ops + PERF_W'(1);
      end
      if (w_stall && (r_perf_stalls != {PERF_W{1'b1}})) begin
        r_perf_stalls <= r_perf_stalls + PERF_W'(1);
      end
    end
  end

  assign bus.md_start    = w_start;
  assign bus.md_write    = w_write;
  assign bus.stall_d     = w_stall;
  assign bus.run_kind    = r_state;
  assign bus.err_sync    = r_err_sync;
  assign bus.err_overlap = r_err_overlap;
  assign bus.perf_ops    = r_perf_ops;
  assign bus.perf_stalls = r_perf_stalls;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - scoreboard bench for md_issue_ctrl with a 32-bit and a 4-bit perf build
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  md_issue_ctrl_if #(.PERF_W(32)) u_if ();
  md_issue_ctrl_if #(.PERF_W(4))  u_if4 ();

  md_issue_ctrl #(.PERF_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  md_issue_ctrl #(.PERF_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4.slave)
  );

  typedef struct packed {
    logic        start;
    logic        write;
    logic        stall;
    logic [1:0]  kind;
    logic        esync;
    logic        eovl;
    logic [31:0] ops;
    logic [31:0] stalls;
    logic [3:0]  ops4;
    logic [3:0]  stalls4;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: the unit is "occupied" for a number of remaining cycles after a start.
  int          m_left = 0;
  int          m_kind = 0;
  bit          m_esync = 0;
  bit          m_eovl = 0;
  bit          m_first = 1;
  longint      m_ops = 0;
  longint      m_stalls = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic step(input int dop, input bit drd, input bit ev, input int eop,
                      input bit rq, input bit bfault, input bit rst);
    exp_t e;
    bit   idle, is_s, is_w, dmd, busy, st, wr, stl;
    @(posedge clk);
    #1;
    idle = (m_left == 0);
    busy = !idle ^ bfault;
    reset = rst;
    u_if.d_md_op  = 3'(dop);  u_if4.d_md_op  = 3'(dop);
    u_if.d_md_read = drd;     u_if4.d_md_read = drd;
    u_if.e_valid  = ev;       u_if4.e_valid  = ev;
    u_if.e_md_op  = 3'(eop);  u_if4.e_md_op  = 3'(eop);
    u_if.req      = rq;       u_if4.req      = rq;
    u_if.md_busy  = busy;     u_if4.md_busy  = busy;

    is_s = (eop >= 1 && eop <= 4);
    is_w = (eop == 5 || eop == 6);
    dmd  = (dop >= 1 && dop <= 6) || drd;
    st   = ev && is_s && !rq && idle;
    wr   = ev && is_w && !rq && idle;
    stl  = dmd && (!idle || st || busy);

    e.start   = st;
    e.write   = wr;
    e.stall   = stl;
    e.kind    = 2'(m_kind);
    e.esync   = m_esync;
    e.eovl    = m_eovl;
    e.ops     = 32'(m_ops);
    e.stalls  = 32'(m_stalls);
    e.ops4    = 4'(sat(m_ops, 15));
    e.stalls4 = 4'(sat(m_stalls, 15));
    exp_q.push_back(e);

    if (rst) begin
      m_left = 0; m_kind = 0; m_esync = 0; m_eovl = 0; m_first = 1;
      m_ops = 0; m_stalls = 0;
    end else begin
      if (!m_first && (busy != !idle)) m_esync = 1;
      m_first = 0;
      if (ev && (is_s || is_w) && !rq && !idle) m_eovl = 1;
      if (st) m_ops++;
      if (stl) m_stalls++;
      if (st) begin
        m_left = (eop <= 2) ? 5 : 10;
        m_kind = (eop <= 2) ? 1 : 2;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_kind = 0;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("md_start",    64'(u_if.md_start),    64'(e.start));
        chk("md_write",    64'(u_if.md_write),    64'(e.write));
        chk("stall_d",     64'(u_if.stall_d),     64'(e.stall));
        chk("run_kind",    64'(u_if.run_kind),    64'(e.kind));
        chk("err_sync",    64'(u_if.err_sync),    64'(e.esync));
        chk("err_overlap", 64'(u_if.err_overlap), 64'(e.eovl));
        chk("perf_ops",    64'(u_if.perf_ops),    64'(e.ops));
        chk("perf_stalls", 64'(u_if.perf_stalls), 64'(e.stalls));
        chk("perf_ops_w4",    64'(u_if4.perf_ops),    64'(e.ops4));
        chk("perf_stalls_w4", 64'(u_if4.perf_stalls), 64'(e.stalls4));
      end
    end
  end

  initial begin : driver
    int eop;
    u_if.d_md_op = 3'd0;  u_if4.d_md_op = 3'd0;
    u_if.d_md_read = 1'b0; u_if4.d_md_read = 1'b0;
    u_if.e_valid = 1'b0;  u_if4.e_valid = 1'b0;
    u_if.e_md_op = 3'd0;  u_if4.e_md_op = 3'd0;
    u_if.req = 1'b0;      u_if4.req = 1'b0;
    u_if.md_busy = 1'b0;  u_if4.md_busy = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0, 0, 0, 0);
    // MULT with MFLO waiting in D
    step(0, 1, 1, 1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0, 0);
    // DIVU, then DIV held in D until the unit frees
    step(3, 0, 1, 4, 0, 0, 0);
    repeat (10) step(3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 0);
    // flush suppresses a MULT start; MTHI with MFHI in D
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 5, 0, 0, 0);
    step(7, 0, 1, 7, 0, 0, 0);
    // MTLO forced while a MULT runs, then busy dropped and reset mid-run
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 6, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      eop = int'($urandom_range(0, 7));
      if (m_left > 0 && ($urandom % 10) != 0) eop = 0;
      step(int'($urandom_range(0, 7)), ($urandom % 4) == 0, ($urandom % 4) != 0, eop,
           ($urandom % 10) == 0, ($urandom % 40) == 0, ($urandom % 60) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
